// File: rtl/mux_rr_arbiter.sv
// Round-robin owner sequencer for the shared 8:1 tristate mux: picks one requester, drives s/en/gnt,
// and inserts a one-cycle enable-low turnaround between owners so two drivers never overlap.
module mux_rr_arbiter #(
   parameter int N        = 8,
   parameter int SELW     = 3,
   parameter int MAX_HOLD = 16,
   parameter int HOLDW    = $clog2(MAX_HOLD)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   output logic [SELW-1:0] s,
   output logic            en,
   output logic [N-1:0]    gnt,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);

   state_t          state_q, state_d;
   logic [SELW-1:0] s_q, s_d;
   logic            en_q, en_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic [SELW-1:0] last_q, last_d;
   logic [HOLDW-1:0] cnt_q, cnt_d;

   logic            win_vld;
   logic [SELW-1:0] win_idx;
   logic [SELW-1:0] scan_idx;
   logic [N-1:0]    owner_oh;
   logic            others_pending;

   // Scan from the farthest offset down so the nearest requester after last wins; offset N is last itself.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int k = N; k >= 1; k--) begin
         scan_idx = last_q + SELW'(k);
         if (req[scan_idx]) begin
            win_vld = 1'b1;
            win_idx = scan_idx;
         end
      end
   end

   assign owner_oh       = N'(1) << s_q;
   assign others_pending = |(req & ~owner_oh);

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      en_d    = 1'b0;
      gnt_d   = '0;
      busy_d  = 1'b0;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, GAP: begin
            if (win_vld) begin
               state_d = GRANT;
               s_d     = win_idx;
               last_d  = win_idx;
               en_d    = 1'b1;
               gnt_d   = N'(1) << win_idx;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            // Release takes precedence over hold expiry; both lead to the same GAP cycle.
            if (!req[s_q] || (cnt_q == HOLD_LAST && others_pending)) begin
               state_d = GAP;
               busy_d  = 1'b1;
            end else begin
               en_d   = 1'b1;
               gnt_d  = owner_oh;
               busy_d = 1'b1;
               if (cnt_q != HOLD_LAST) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         en_q    <= 1'b0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         last_q  <= SELW'(N - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         en_q    <= en_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s    = s_q;
   assign en   = en_q;
   assign gnt  = gnt_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: hand-computed owner sequences, hold expiry, release and reset cases.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [2:0] s;
   logic       en;
   logic [7:0] gnt;
   logic       busy;

   int checks;
   int errors;
   bit mon_on;

   mux_rr_arbiter #(.N(8), .SELW(3), .MAX_HOLD(16), .HOLDW(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .s    (s),
      .en   (en),
      .gnt  (gnt),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      step();
      chk("rst_s", s, 0);
      chk("rst_en", en, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
   endtask

   task automatic chk_grant(input string tag, input int o);
      chk({tag, "_s"}, s, o);
      chk({tag, "_en"}, en, 1);
      chk({tag, "_gnt"}, gnt, 32'h1 << o);
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic chk_gap(input string tag);
      chk({tag, "_en"}, en, 0);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_busy"}, busy, 1);
   endtask

   // gnt must always be zero or exactly the one-hot of s while en is high.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("mon_onehot", {31'b0, $countones(gnt) <= 1}, 1);
         chk("mon_gnt_vs_s", gnt, en ? (32'h1 << s) : 32'h0);
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      mon_on = 1'b0;
      rst_n  = 1'b0;
      req    = 8'h00;

      // Idle with no requests, then a single request from 4.
      do_reset();
      mon_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_en", en, 0);
         chk("idle_gnt", gnt, 0);
         chk("idle_s", s, 0);
         chk("idle_busy", busy, 0);
      end
      req = 8'h10;
      step();
      chk_grant("first4", 4);

      // All requesting: 0..7 then 0, 16 grant cycles each plus one gap.
      do_reset();
      req = 8'hFF;
      for (int o = 0; o < 8; o++) begin
         for (int c = 0; c < 16; c++) begin
            step();
            chk_grant("rr", o);
         end
         step();
         chk_gap("rr_gap");
      end
      step();
      chk_grant("rr_wrap", 0);

      // Sole requester keeps the line past MAX_HOLD, then releases.
      do_reset();
      req = 8'h04;
      for (int c = 0; c < 100; c++) begin
         step();
         chk_grant("sole", 2);
      end
      req = 8'h00;
      step();
      chk_gap("sole_rel");
      chk("sole_rel_s", s, 2);
      step();
      chk("sole_idle_busy", busy, 0);
      chk("sole_idle_en", en, 0);
      chk("sole_idle_s", s, 2);

      // Owner 6 preempted by 0 (wrap past 7), then regains after 0 releases.
      do_reset();
      req = 8'h40;
      step();
      chk_grant("o6", 6);
      req = 8'h41;
      for (int c = 0; c < 15; c++) begin
         step();
         chk_grant("o6_hold", 6);
      end
      step();
      chk_gap("o6_pre");
      step();
      chk_grant("o0_wrap", 0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk_grant("o0_hold", 0);
      end
      req = 8'h40;
      step();
      chk_gap("o0_rel");
      step();
      chk_grant("o6_back", 6);

      // Owner 3 releases on the same edge its hold expires while 5 waits.
      do_reset();
      req = 8'h08;
      step();
      chk_grant("o3", 3);
      req = 8'h28;
      for (int c = 0; c < 15; c++) begin
         step();
         chk_grant("o3_hold", 3);
      end
      req = 8'h20;
      step();
      chk_gap("o3_rel");
      step();
      chk_grant("o5", 5);

      // Reset during owner 2's grant: no gap, restart at index 0.
      do_reset();
      req = 8'h04;
      step();
      chk_grant("o2", 2);
      req = 8'hFF;
      step();
      step();
      chk_grant("o2_ff", 2);
      rst_n = 1'b0;
      step();
      chk("midrst_s", s, 0);
      chk("midrst_en", en, 0);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_busy", busy, 0);
      rst_n = 1'b1;
      step();
      chk_grant("after_rst", 0);

      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
